// File: rtl/imem_loader_pkg.sv
// Shared state encoding and stream-format constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam int LEN_BYTES      = 2;  // big-endian 16-bit word count
  localparam int CHECK_BYTES    = 1;  // trailing XOR checksum
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8 * LEN_BYTES;

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Shifts stream bytes MSB-first into a 32-bit word; word_valid strobes the cycle after the 4th byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  index,
  output logic        word_valid
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word       <= '0;
      index      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift && (index == LAST_IDX);
      if (shift) begin
        word  <= {word[23:0], byte_in};
        index <= index + 2'd1;  // wraps 3 -> 0
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: length header, big-endian payload words, XOR checksum.
// Handshake: a byte moves only in a cycle where byte_valid && byte_ready are both high.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output state_t      fsm_state
);

  localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

  state_t             state, next_state;
  logic               ready_st;
  logic               accept;
  logic               start_ok;
  logic               shift;
  logic [7:0]         len_hi;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_full;
  logic [LEN_W-1:0]   word_cnt;
  logic [7:0]         csum;
  logic               last_word;
  logic [31:0]        word;
  logic [1:0]         index;
  logic               word_valid;

  assign byte_ready = ready_st && !rst;
  assign accept     = byte_valid && byte_ready;
  assign start_ok   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign shift      = accept && (state == ST_DATA);
  assign len_full   = {len_hi, byte_in};
  assign last_word  = (word_cnt == len - LEN_W'(1));

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .shift      (shift),
    .byte_in    (byte_in),
    .word       (word),
    .index      (index),
    .word_valid (word_valid)
  );

  // rst gates the strobe combinationally so a write pending from the 4th byte is dropped.
  assign im_we     = word_valid && !rst;
  assign im_addr   = 32'(word_cnt);
  assign im_wdata  = word;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) next_state = ST_LEN_HI;
      ST_LEN_HI: if (accept) next_state = ST_LEN_LO;
      ST_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > DEPTH_L) next_state = ST_ERROR;
          else if (len_full == '0)        next_state = ST_CHECK;
          else                            next_state = ST_DATA;
        end
      end
      ST_DATA:  if (shift && index == LAST_IDX && last_word) next_state = ST_CHECK;
      ST_CHECK: if (accept) next_state = (byte_in == csum) ? ST_DONE : ST_ERROR;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_st = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK: begin
        ready_st = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE:  begin done = 1'b1; cpu_hold = 1'b0; end
      ST_ERROR: error = 1'b1;
      default:  ;
    endcase
  end

  // Word counter advances in the write cycle, so im_addr shows the address being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi   <= '0;
      len      <= '0;
      word_cnt <= '0;
      csum     <= '0;
    end else begin
      if (start_ok) begin
        word_cnt <= '0;
        csum     <= '0;
      end
      if (accept && state == ST_LEN_HI) len_hi <= byte_in;
      if (accept && state == ST_LEN_LO) len <= len_full;
      if (shift)      csum     <= csum ^ byte_in;
      if (word_valid) word_cnt <= word_cnt + LEN_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed stream scenarios plus randomized gap/start-noise loads against a stream model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, im_we, cpu_hold, busy, done, error;
  logic [31:0] im_addr, im_wdata;
  state_t      fsm_state;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];   // expected writes {addr, data}
  logic [63:0] act_q[$];   // observed writes {addr, data}
  logic [63:0] ref_q[$];   // writes from a gap-free run
  logic [7:0]  stream_q[$];
  logic        exp_done;
  int          consumed;
  int          gap_max = 0;
  bit          start_noise = 1'b0;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .fsm_state  (fsm_state)
  );

  // clock / reset / monitor
  always #5 clk = ~clk;

  always @(negedge clk) if (im_we) act_q.push_back({im_addr, im_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // reference model: expected writes and outcome from the stream rules
  task automatic model_stream();
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    n = int'({stream_q[0], stream_q[1]});
    if (n > DEPTH) begin
      exp_done = 1'b0;
      consumed = LEN_BYTES;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        w = (w << 8) | 32'(stream_q[LEN_BYTES + 4 * i + k]);
        x = x ^ stream_q[LEN_BYTES + 4 * i + k];
      end
      exp_q.push_back({32'(i), w});
    end
    consumed = LEN_BYTES + 4 * n + CHECK_BYTES;
    exp_done = (stream_q[consumed - 1] == x);
  endtask

  task automatic build_stream(input int n, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    stream_q.delete();
    stream_q.push_back(8'(n >> 8));
    stream_q.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stream_q.push_back(b);
      x = x ^ b;
    end
    stream_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_max > 0) begin
      repeat ($urandom_range(0, gap_max)) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        start      = start_noise && ($urandom_range(0, 2) == 0);
        @(posedge clk); #2;
        start      = 1'b0;
      end
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout byte=%02h got byte_ready=%0b want 1", b, byte_ready);
    end
    @(posedge clk); #2;
    byte_valid = 1'b0;
  endtask

  task automatic play_stream();
    act_q.delete();
    pulse_start();
    for (int i = 0; i < consumed; i++) send_byte(stream_q[i]);
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
    @(posedge clk); #2;
    @(negedge clk);
    checks++;
    if ({im_we, byte_ready, busy, done, error, cpu_hold} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_flags got we/rdy/busy/done/err/hold=%06b want 000001",
               {im_we, byte_ready, busy, done, error, cpu_hold});
    end
    checks++;
    if (im_addr !== 32'h0 || im_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus got addr=%08h wdata=%08h want 0/0", im_addr, im_wdata);
    end
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_start_priority got state=%0d want %0d", fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_directed_ok();
    // XOR of the payload 12..F0 is 0x00
    stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    model_stream();
    play_stream();
    checks++;
    if (act_q.size() != 2) begin
      errors++; $display("FAIL ok_write_count got %0d want 2", act_q.size());
    end else begin
      checks++;
      if (act_q[0] !== 64'h0000_0000_1234_5678) begin
        errors++; $display("FAIL ok_word0 got %016h want 0000000012345678", act_q[0]);
      end
      checks++;
      if (act_q[1] !== 64'h0000_0001_9ABC_DEF0) begin
        errors++; $display("FAIL ok_word1 got %016h want 000000019abcdef0", act_q[1]);
      end
    end
    checks++;
    if ({done, error, cpu_hold, busy} !== 4'b1000) begin
      errors++; $display("FAIL ok_flags got done/err/hold/busy=%04b want 1000", {done, error, cpu_hold, busy});
    end
  endtask

  task automatic test_bad_checksum();
    stream_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h89};
    model_stream();
    play_stream();
    checks++;
    if (act_q.size() != 2 || act_q[1] !== 64'h0000_0001_9ABC_DEF0) begin
      errors++; $display("FAIL badsum_writes got count=%0d want 2 with last 000000019abcdef0", act_q.size());
    end
    checks++;
    if ({done, error, cpu_hold} !== 3'b011) begin
      errors++; $display("FAIL badsum_flags got done/err/hold=%03b want 011", {done, error, cpu_hold});
    end
  endtask

  task automatic test_too_long();
    stream_q = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    model_stream();
    play_stream();
    checks++;
    if (act_q.size() != 0 || fsm_state !== ST_ERROR || error !== 1'b1) begin
      errors++; $display("FAIL too_long got writes=%0d state=%0d err=%0b want 0/%0d/1",
                         act_q.size(), fsm_state, error, ST_ERROR);
    end
  endtask

  task automatic test_depth_boundary();
    build_stream(DEPTH, 1'b1);
    model_stream();
    play_stream();
    checks++;
    if (act_q.size() != DEPTH) begin
      errors++; $display("FAIL depth_count got %0d want %0d", act_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (act_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL depth_word%0d got %016h want %016h", i, act_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL depth_done got %0b want 1", done);
    end
  endtask

  task automatic test_zero_len();
    stream_q = '{8'h00, 8'h00, 8'h00};
    model_stream();
    play_stream();
    checks++;
    if (act_q.size() != 0 || {done, error, cpu_hold} !== 3'b100) begin
      errors++; $display("FAIL zero_len got writes=%0d done/err/hold=%03b want 0/100",
                         act_q.size(), {done, error, cpu_hold});
    end
  endtask

  task automatic test_idle_bytes_ignored();
    act_q.delete();
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0) begin
        errors++; $display("FAIL idle_ready got %0b want 0", byte_ready);
      end
      @(posedge clk); #2;
    end
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_state !== ST_DONE || act_q.size() != 0) begin
      errors++; $display("FAIL idle_bytes got state=%0d writes=%0d want %0d/0", fsm_state, act_q.size(), ST_DONE);
    end
  endtask

  task automatic test_reset_mid_load();
    build_stream(2, 1'b1);
    model_stream();
    act_q.delete();
    pulse_start();
    for (int i = 0; i < LEN_BYTES + 7; i++) send_byte(stream_q[i]);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (act_q.size() != 1 || act_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL midrst_writes got count=%0d want 1 (%016h)", act_q.size(), exp_q[0]);
    end
    checks++;
    if (fsm_state !== ST_IDLE || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL midrst_state got state=%0d hold=%0b want %0d/1", fsm_state, cpu_hold, ST_IDLE);
    end
    // reset in the cycle a write is pending
    act_q.delete();
    pulse_start();
    for (int i = 0; i < LEN_BYTES + 4; i++) send_byte(stream_q[i]);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (act_q.size() != 0) begin
      errors++; $display("FAIL pending_abort got writes=%0d want 0", act_q.size());
    end
    play_stream();
    checks++;
    if (act_q.size() != 2 || act_q[0] !== exp_q[0] || act_q[1] !== exp_q[1] || done !== 1'b1) begin
      errors++; $display("FAIL reload got count=%0d done=%0b want 2/1", act_q.size(), done);
    end
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 6; it++) begin
      build_stream($urandom_range(1, 8), $urandom_range(0, 3) != 0);
      model_stream();
      gap_max = 0; start_noise = 1'b0;
      play_stream();
      ref_q = act_q;
      checks++;
      if (act_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d want %0d", it, act_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (act_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand%0d_word%0d got %016h want %016h", it, i, act_q[i], exp_q[i]);
          end
        end
      end
      gap_max = 3; start_noise = 1'b1;
      play_stream();
      gap_max = 0; start_noise = 1'b0;
      checks++;
      if (act_q != ref_q) begin
        errors++; $display("FAIL rand%0d_gapped got count=%0d want count=%0d identical words",
                           it, act_q.size(), ref_q.size());
      end
      checks++;
      if ({done, error} !== {exp_done, !exp_done}) begin
        errors++; $display("FAIL rand%0d_outcome got done/err=%0b%0b want %0b%0b",
                           it, done, error, exp_done, !exp_done);
      end
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_directed_ok();
    test_idle_bytes_ignored();
    test_bad_checksum();
    test_too_long();
    test_zero_len();
    test_depth_boundary();
    test_reset_mid_load();
    test_random_gaps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
